// File: rtl/aq_ifu_ras_ctrl_if.sv
// aq_ifu_ras_ctrl_if: return-address-stack control bus between the fetch/retire side and the RAS controller
//   master: drives push/pop/flush/retire requests and the entry PC bus; receives writes and top-of-stack
//   slave : the RAS controller
interface aq_ifu_ras_ctrl_if #(
    parameter int PC_WIDTH = 24,
    parameter int DEPTH    = 4
);
    logic                      ras_push_vld;
    logic [PC_WIDTH-1:0]       ras_push_pc;
    logic                      ras_pop_vld;
    logic                      ras_flush;
    logic                      rtu_ras_push;
    logic                      rtu_ras_pop;
    logic [DEPTH*PC_WIDTH-1:0] ras_entry_pc_bus;
    logic [DEPTH-1:0]          ras_entry_upd;
    logic [PC_WIDTH-1:0]       ras_upd_pc;
    logic                      ras_top_vld;
    logic [PC_WIDTH-1:0]       ras_top_pc;
    logic                      ras_full;
    logic                      ras_empty;

    modport master (
        output ras_push_vld, ras_push_pc, ras_pop_vld, ras_flush, rtu_ras_push, rtu_ras_pop,
               ras_entry_pc_bus,
        input  ras_entry_upd, ras_upd_pc, ras_top_vld, ras_top_pc, ras_full, ras_empty
    );

    modport slave (
        input  ras_push_vld, ras_push_pc, ras_pop_vld, ras_flush, rtu_ras_push, rtu_ras_pop,
               ras_entry_pc_bus,
        output ras_entry_upd, ras_upd_pc, ras_top_vld, ras_top_pc, ras_full, ras_empty
    );
endinterface

// File: rtl/aq_ifu_ras_ctrl.sv
// aq_ifu_ras_ctrl: return address stack pointer/count control with speculative and retired copies
//   entry_clk : clock, rising edge
//   cpurst_b  : asynchronous active-low reset
//   bus       : slave side of aq_ifu_ras_ctrl_if (push/pop/flush/retire in, entry write enables and
//               top-of-stack out; entry storage lives outside and is read back on ras_entry_pc_bus)
module aq_ifu_ras_ctrl #(
    parameter int PC_WIDTH = 24,
    parameter int DEPTH    = 4
) (
    input logic               entry_clk,
    input logic               cpurst_b,
    aq_ifu_ras_ctrl_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]       sptr, rptr, sptr_nxt, rptr_nxt, top_idx;
    logic [CW-1:0]       scnt, rcnt, scnt_nxt, rcnt_nxt;
    logic [PC_WIDTH-1:0] entry [DEPTH];

    // Shared next-state rule for both stack copies; push+pop on a non-empty stack replaces the top.
    function automatic logic [PW+CW-1:0] step(input logic [PW-1:0] p, input logic [CW-1:0] c,
                                              input logic push, input logic pop);
        if (push && !(pop && c != '0))
            return {p + PW'(1), (c == CW'(DEPTH)) ? c : c + CW'(1)};
        if (pop && !push && c != '0)
            return {p - PW'(1), c - CW'(1)};
        return {p, c};
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign entry[i] = bus.ras_entry_pc_bus[i*PC_WIDTH +: PC_WIDTH];
    end

    // A flush restores from the retired state as it will be after this cycle's retire.
    always_comb begin
        {rptr_nxt, rcnt_nxt} = step(rptr, rcnt, bus.rtu_ras_push, bus.rtu_ras_pop);
        {sptr_nxt, scnt_nxt} = bus.ras_flush ? {rptr_nxt, rcnt_nxt}
                                             : step(sptr, scnt, bus.ras_push_vld, bus.ras_pop_vld);
    end

    always_ff @(posedge entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sptr <= '0;
            scnt <= '0;
            rptr <= '0;
            rcnt <= '0;
        end else begin
            sptr <= sptr_nxt;
            scnt <= scnt_nxt;
            rptr <= rptr_nxt;
            rcnt <= rcnt_nxt;
        end
    end

    assign top_idx           = sptr - PW'(1);
    // Writes are suppressed while reset is held so nothing lands in the entries during reset.
    assign bus.ras_entry_upd = (!cpurst_b || bus.ras_flush || !bus.ras_push_vld) ? '0
                             : DEPTH'(1) << ((bus.ras_pop_vld && scnt != '0) ? top_idx : sptr);
    assign bus.ras_upd_pc    = bus.ras_push_pc;
    assign bus.ras_top_vld   = scnt != '0;
    assign bus.ras_top_pc    = bus.ras_top_vld ? entry[top_idx] : '0;
    assign bus.ras_full      = scnt == CW'(DEPTH);
    assign bus.ras_empty     = scnt == '0;
endmodule

// File: tb/tb_aq_ifu_ras_ctrl.sv
// tb_aq_ifu_ras_ctrl: directed self-checking bench for aq_ifu_ras_ctrl with an external entry array
module tb_aq_ifu_ras_ctrl;
    logic entry_clk;
    logic cpurst_b;
    int total = 0;
    int bad = 0;
    logic [23:0] mem [4];

    aq_ifu_ras_ctrl_if #(.PC_WIDTH(24), .DEPTH(4)) bus ();

    aq_ifu_ras_ctrl #(.PC_WIDTH(24), .DEPTH(4)) dut (
        .entry_clk (entry_clk),
        .cpurst_b  (cpurst_b),
        .bus       (bus.slave)
    );

    initial begin
        entry_clk = 1'b0;
        forever #5 entry_clk = ~entry_clk;
    end

    initial for (int k = 0; k < 4; k++) mem[k] = 24'h0;

    always @(posedge entry_clk)
        for (int k = 0; k < 4; k++)
            if (bus.ras_entry_upd[k]) mem[k] <= bus.ras_upd_pc;

    assign bus.ras_entry_pc_bus = {mem[3], mem[2], mem[1], mem[0]};

    task automatic tick();
        @(posedge entry_clk);
        @(negedge entry_clk);
    endtask

    task automatic idle();
        bus.ras_push_vld = 0;
        bus.ras_push_pc  = '0;
        bus.ras_pop_vld  = 0;
        bus.ras_flush    = 0;
        bus.rtu_ras_push = 0;
        bus.rtu_ras_pop  = 0;
    endtask

    task automatic push(input logic [23:0] pc, input logic rtu);
        idle();
        bus.ras_push_vld = 1;
        bus.ras_push_pc  = pc;
        bus.rtu_ras_push = rtu;
    endtask

    task automatic test_reset();
        idle();
        cpurst_b = 0;
        bus.ras_push_vld = 1;
        bus.ras_push_pc  = 24'h123456;
        tick();
        total++; if (bus.ras_entry_upd !== 4'b0000) begin $display("FAIL reset_upd got=%b exp=0000", bus.ras_entry_upd); bad++; end
        total++; if (bus.ras_upd_pc !== 24'h123456) begin $display("FAIL reset_upd_pc got=%h exp=123456", bus.ras_upd_pc); bad++; end
        total++; if (bus.ras_top_vld !== 1'b0) begin $display("FAIL reset_top_vld got=%b exp=0", bus.ras_top_vld); bad++; end
        total++; if (bus.ras_top_pc !== 24'h0) begin $display("FAIL reset_top_pc got=%h exp=0", bus.ras_top_pc); bad++; end
        total++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin $display("FAIL reset_flags got empty=%b full=%b exp 1/0", bus.ras_empty, bus.ras_full); bad++; end
        idle();
        cpurst_b = 1;
        tick();
    endtask

    task automatic test_push_pop();
        logic [23:0] pcs [3];
        logic [3:0]  oh  [3];
        pcs = '{24'h000100, 24'h000200, 24'h000300};
        oh  = '{4'b0001, 4'b0010, 4'b0100};
        for (int k = 0; k < 3; k++) begin
            push(pcs[k], 0);
            #1;
            total++; if (bus.ras_entry_upd !== oh[k]) begin $display("FAIL push_upd%0d got=%b exp=%b", k, bus.ras_entry_upd, oh[k]); bad++; end
            if (k > 0) begin
                total++; if (bus.ras_top_pc !== pcs[k-1]) begin $display("FAIL no_bypass%0d got=%h exp=%h", k, bus.ras_top_pc, pcs[k-1]); bad++; end
            end
            tick();
        end
        idle();
        total++; if (bus.ras_top_pc !== 24'h000300 || bus.ras_top_vld !== 1'b1) begin $display("FAIL push_top got=%h vld=%b exp=000300/1", bus.ras_top_pc, bus.ras_top_vld); bad++; end
        for (int k = 1; k >= 0; k--) begin
            bus.ras_pop_vld = 1;
            #1;
            total++; if (bus.ras_entry_upd !== 4'b0000) begin $display("FAIL pop_upd got=%b exp=0000", bus.ras_entry_upd); bad++; end
            tick();
            total++; if (bus.ras_top_pc !== pcs[k]) begin $display("FAIL pop_top%0d got=%h exp=%h", k, bus.ras_top_pc, pcs[k]); bad++; end
        end
        tick();
        idle();
        total++; if (bus.ras_empty !== 1'b1 || bus.ras_top_vld !== 1'b0) begin $display("FAIL pop_empty got empty=%b vld=%b exp 1/0", bus.ras_empty, bus.ras_top_vld); bad++; end
    endtask

    task automatic test_wrap();
        logic [23:0] tops [4];
        tops = '{24'h50, 24'h40, 24'h30, 24'h20};
        for (int k = 1; k <= 4; k++) begin
            push(24'(k * 16), 0);
            tick();
        end
        idle();
        total++; if (bus.ras_full !== 1'b1) begin $display("FAIL wrap_full got=%b exp=1", bus.ras_full); bad++; end
        push(24'h50, 0);
        #1;
        total++; if (bus.ras_entry_upd !== 4'b0001) begin $display("FAIL wrap_upd got=%b exp=0001", bus.ras_entry_upd); bad++; end
        tick();
        idle();
        total++; if (bus.ras_full !== 1'b1) begin $display("FAIL wrap_still_full got=%b exp=1", bus.ras_full); bad++; end
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.ras_top_pc !== tops[k]) begin $display("FAIL wrap_pop%0d got=%h exp=%h", k, bus.ras_top_pc, tops[k]); bad++; end
            bus.ras_pop_vld = 1;
            tick();
        end
        idle();
        total++; if (bus.ras_empty !== 1'b1) begin $display("FAIL wrap_empty got=%b exp=1", bus.ras_empty); bad++; end
    endtask

    task automatic test_underflow();
        idle();
        bus.ras_pop_vld = 1;
        #1;
        total++; if (bus.ras_entry_upd !== 4'b0000) begin $display("FAIL under_upd got=%b exp=0000", bus.ras_entry_upd); bad++; end
        tick();
        idle();
        total++; if (bus.ras_top_vld !== 1'b0 || bus.ras_top_pc !== 24'h0) begin $display("FAIL under_top got vld=%b pc=%h exp 0/0", bus.ras_top_vld, bus.ras_top_pc); bad++; end
        total++; if (dut.sptr !== 2'd1 || dut.scnt !== 3'd0) begin $display("FAIL under_state got sptr=%0d scnt=%0d exp 1/0", dut.sptr, dut.scnt); bad++; end
    endtask

    task automatic test_back_to_back();
        push(24'hA0, 0);
        tick();
        push(24'hB0, 0);
        bus.ras_pop_vld = 1;
        #1;
        total++; if (bus.ras_entry_upd !== 4'b0010) begin $display("FAIL repl_upd got=%b exp=0010", bus.ras_entry_upd); bad++; end
        tick();
        idle();
        total++; if (bus.ras_top_pc !== 24'hB0) begin $display("FAIL repl_top got=%h exp=b0", bus.ras_top_pc); bad++; end
        total++; if (dut.scnt !== 3'd1 || dut.sptr !== 2'd2) begin $display("FAIL repl_state got scnt=%0d sptr=%0d exp 1/2", dut.scnt, dut.sptr); bad++; end
        bus.ras_pop_vld = 1;
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle();
        bus.ras_flush = 1;
        tick();
        push(24'h1, 1);
        tick();
        push(24'h2, 1);
        tick();
        push(24'h3, 0);
        tick();
        push(24'h77, 0);
        bus.ras_flush = 1;
        #1;
        total++; if (bus.ras_entry_upd !== 4'b0000) begin $display("FAIL flush_upd got=%b exp=0000", bus.ras_entry_upd); bad++; end
        tick();
        idle();
        total++; if (dut.scnt !== 3'd2 || bus.ras_top_pc !== 24'h2) begin $display("FAIL flush_top got scnt=%0d top=%h exp 2/000002", dut.scnt, bus.ras_top_pc); bad++; end
        push(24'h4, 0);
        tick();
        idle();
        bus.ras_flush   = 1;
        bus.rtu_ras_pop = 1;
        tick();
        idle();
        total++; if (dut.scnt !== 3'd1 || bus.ras_top_pc !== 24'h1) begin $display("FAIL flush_retire got scnt=%0d top=%h exp 1/000001", dut.scnt, bus.ras_top_pc); bad++; end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            push(24'(k + 8), 1);
            tick();
        end
        idle();
        total++; if (bus.ras_full !== 1'b1 || dut.rcnt !== 3'd4) begin $display("FAIL mid_prefill got full=%b rcnt=%0d exp 1/4", bus.ras_full, dut.rcnt); bad++; end
        push(24'hCC, 1);
        #1;
        cpurst_b = 0;
        #1;
        total++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0 || bus.ras_entry_upd !== 4'b0000) begin $display("FAIL mid_flags got empty=%b full=%b upd=%b exp 1/0/0000", bus.ras_empty, bus.ras_full, bus.ras_entry_upd); bad++; end
        total++; if (dut.scnt !== 3'd0 || dut.rcnt !== 3'd0 || dut.sptr !== 2'd0 || dut.rptr !== 2'd0) begin $display("FAIL mid_state got scnt=%0d rcnt=%0d sptr=%0d rptr=%0d exp all 0", dut.scnt, dut.rcnt, dut.sptr, dut.rptr); bad++; end
        tick();
        total++; if (bus.ras_top_vld !== 1'b0 || bus.ras_top_pc !== 24'h0) begin $display("FAIL mid_hold got vld=%b pc=%h exp 0/0", bus.ras_top_vld, bus.ras_top_pc); bad++; end
        idle();
        cpurst_b = 1;
        tick();
    endtask

    initial begin
        idle();
        cpurst_b = 0;
        @(negedge entry_clk);
        test_reset();
        test_push_pop();
        test_wrap();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
